// File: rtl/calc_arbiter_seq.sv
// Round-robin sequencer sharing one CombCalc between two valid/ready requesters,
// with per-requester accumulators, a tagged response channel and an overflow counter.

module CombCalc #(
  parameter int W = 16
) (
  input  logic [2:0]          op,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] r,
  output logic                ovf
);
  logic signed [W:0] ax;
  logic signed [W:0] bx;
  logic signed [W:0] ext;

  assign ax = {a[W-1], a};
  assign bx = {b[W-1], b};

  // One guard bit: overflow whenever the W+1 bit result does not fit in W bits.
  always_comb begin
    ext = '0;
    case (op)
      3'b000, 3'b100: ext = ax + bx;
      3'b001:         ext = ax - bx;
      3'b101:         ext = bx - ax;
      3'b010, 3'b011: ext = b[W-1] ? -bx : bx;
      default:        ext = a[W-1] ? -ax : ax;
    endcase
    r   = ext[W-1:0];
    ovf = ext[W] != ext[W-1];
  end
endmodule

module calc_arbiter_seq #(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [2:0]          req0_op,
  input  logic signed [W-1:0] req0_a,
  input  logic signed [W-1:0] req0_b,
  input  logic                req0_use_acc,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [2:0]          req1_op,
  input  logic signed [W-1:0] req1_a,
  input  logic signed [W-1:0] req1_b,
  input  logic                req1_use_acc,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic signed [W-1:0] rsp_r,
  output logic                rsp_ovf,
  output logic                busy,
  output logic [CW-1:0]       ovf_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state;
  logic                rr;
  logic [2:0]          op_q;
  logic signed [W-1:0] a_q;
  logic signed [W-1:0] b_q;
  logic                id_q;
  logic signed [W-1:0] acc0;
  logic signed [W-1:0] acc1;
  logic signed [W-1:0] calc_r;
  logic                calc_ovf;
  logic                grant1;

  // rr=0 favours requester 0; a lone valid is always granted.
  assign grant1     = req1_valid && (!req0_valid || rr);
  assign req1_ready = (state == IDLE) && grant1;
  assign req0_ready = (state == IDLE) && req0_valid && !grant1;
  assign busy       = (state != IDLE);

  CombCalc #(.W(W)) u_calc (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .r   (calc_r),
    .ovf (calc_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      acc0      <= '0;
      acc1      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_r     <= '0;
      rsp_ovf   <= 1'b0;
      ovf_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            op_q  <= req0_op;
            a_q   <= req0_use_acc ? acc0 : req0_a;
            b_q   <= req0_b;
            id_q  <= 1'b0;
            state <= EXEC;
          end else if (req1_ready) begin
            op_q  <= req1_op;
            a_q   <= req1_use_acc ? acc1 : req1_a;
            b_q   <= req1_b;
            id_q  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_r     <= calc_r;
          rsp_ovf   <= calc_ovf;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          if (id_q) acc1 <= calc_r;
          else      acc0 <= calc_r;
          if (calc_ovf && ovf_count != '1) ovf_count <= ovf_count + CW'(1);
          rr    <= ~id_q;
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_arbiter_seq.sv
// Randomized and directed checks of calc_arbiter_seq against a transaction-level
// reference model of the arbitration, latency, accumulator and overflow rules.

module tb_calc_arbiter_seq;
  localparam int W  = 16;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0_valid, req0_ready, req0_use_acc;
  logic req1_valid, req1_ready, req1_use_acc;
  logic [2:0] req0_op, req1_op;
  logic signed [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
  logic signed [W-1:0] rsp_r;
  logic [CW-1:0] ovf_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int macc[2];
  int mcnt;
  bit mrr;
  int mphase;  // 0 idle, 1 computing, 2 response pending
  bit mid;
  int mr;
  bit movf;

  always #5 clk = ~clk;

  calc_arbiter_seq #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_use_acc(req0_use_acc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_use_acc(req1_use_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_r(rsp_r), .rsp_ovf(rsp_ovf), .busy(busy), .ovf_count(ovf_count)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void calc(input logic [2:0] op, input int a, input int b,
                               output int r, output bit ovf);
    int full;
    case (op)
      3'd0:       full = a + b;
      3'd1:       full = a - b;
      3'd2, 3'd3: full = (b < 0) ? -b : b;
      3'd4:       full = b + a;
      3'd5:       full = b - a;
      default:    full = (a < 0) ? -a : a;
    endcase
    ovf = (full > 32767) || (full < -32768);
    r = ((full + 32768) & 65535) - 32768;
  endfunction

  function automatic void model_reset();
    macc[0] = 0; macc[1] = 0; mcnt = 0; mrr = 0; mphase = 0; mid = 0; mr = 0; movf = 0;
  endfunction

  // Called just after a falling edge with inputs already driven; ends at the next falling edge.
  task automatic tick();
    bit e0, e1;
    int av, bv;
    #1;
    e0 = 0; e1 = 0;
    if (mphase == 0) begin
      e1 = req1_valid && (!req0_valid || mrr);
      e0 = req0_valid && !e1;
    end
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    check("busy", busy, mphase != 0);
    check("rsp_valid", rsp_valid, mphase == 2);
    if (mphase == 2) begin
      check("rsp_id", rsp_id, mid);
      check("rsp_r", $signed(rsp_r), mr);
      check("rsp_ovf", rsp_ovf, movf);
    end
    check("ovf_count", ovf_count, mcnt);
    @(posedge clk);
    case (mphase)
      0: if (e0 || e1) begin
        mid = e1;
        if (e1) begin
          av = req1_use_acc ? macc[1] : int'(req1_a);
          bv = int'(req1_b);
          calc(req1_op, av, bv, mr, movf);
        end else begin
          av = req0_use_acc ? macc[0] : int'(req0_a);
          bv = int'(req0_b);
          calc(req0_op, av, bv, mr, movf);
        end
        mphase = 1;
      end
      1: begin
        macc[mid] = mr;
        if (movf && mcnt < CMAX) mcnt++;
        mrr = !mid;
        mphase = 2;
      end
      default: if (rsp_ready) mphase = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic drop();
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic req(input bit n, input logic [2:0] op, input int a, input int b, input bit ua);
    if (n) begin
      req1_valid = 1; req1_op = op; req1_a = W'(a); req1_b = W'(b); req1_use_acc = ua;
    end else begin
      req0_valid = 1; req0_op = op; req0_a = W'(a); req0_b = W'(b); req0_use_acc = ua;
    end
  endtask

  // Single issue: accept, then let the transaction finish with the current rsp_ready.
  task automatic issue(input bit n, input logic [2:0] op, input int a, input int b, input bit ua);
    drop();
    req(n, op, a, b, ua);
    tick();
    drop();
    repeat (3) tick();
  endtask

  task automatic reset_dut();
    drop();
    rst = 1;
    #1;
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_id", rsp_id, 0);
    check("rst rsp_r", $signed(rsp_r), 0);
    check("rst rsp_ovf", rsp_ovf, 0);
    check("rst busy", busy, 0);
    check("rst ovf_count", ovf_count, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  function automatic logic signed [W-1:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 16'sh7fff;
      1:       return 16'sh8000;
      2:       return W'($urandom_range(0, 3));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0; req0_use_acc = 0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0; req1_use_acc = 0;
    rsp_ready = 1;
    model_reset();
    #2;
    reset_dut();

    // Basic add, then chain on the accumulator
    issue(0, 3'b000, 7, 5, 0);
    issue(0, 3'b001, 0, 20, 1);
    issue(1, 3'b000, 0, 0, 1);

    // Overflow, counter saturation
    repeat (5) issue(1, 3'b000, 32767, 1, 0);

    // Both requesters continuously valid: grants alternate starting with 0
    reset_dut();
    req(0, 3'b000, 1, 2, 0);
    req(1, 3'b101, 3, 10, 0);
    repeat (14) tick();
    drop();
    repeat (3) tick();

    // Backpressure held for several cycles, then release with both waiting
    req(1, 3'b100, 100, 23, 0);
    tick();
    drop();
    rsp_ready = 0;
    repeat (7) tick();
    req(0, 3'b001, 4, 9, 0);
    req(1, 3'b000, 4, 9, 0);
    rsp_ready = 1;
    repeat (6) tick();
    drop();
    repeat (3) tick();

    // Absolute value, then reset while computing
    issue(1, 3'b110, -9, 0, 0);
    issue(1, 3'b010, 0, -32768, 0);
    drop();
    req(1, 3'b110, -9, 0, 0);
    tick();
    drop();
    reset_dut();
    issue(1, 3'b000, 0, 0, 1);
    issue(0, 3'b100, 0, 5, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_op = 3'($urandom); req1_op = 3'($urandom);
      req0_a = rand_val(); req0_b = rand_val();
      req1_a = rand_val(); req1_b = rand_val();
      req0_use_acc = ($urandom_range(0, 2) == 0);
      req1_use_acc = ($urandom_range(0, 2) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rsp_ready = 1;
    drop();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
